// File: rtl/bayer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bayer_pkg : shared constants and types for the Bayer window path  |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
package bayer_pkg;

  localparam int WIN_TAPS = 9;

  // Tap index in raster order; R0C0 lands in the MSBs of the window bus.
  localparam int R0C0 = 0;
  localparam int R0C1 = 1;
  localparam int R0C2 = 2;
  localparam int R1C0 = 3;
  localparam int R1C1 = 4;
  localparam int R1C2 = 5;
  localparam int R2C0 = 6;
  localparam int R2C1 = 7;
  localparam int R2C2 = 8;

  typedef struct packed {
    logic r0;
    logic r1;
    logic r2;
  } row_vld_t;

  function automatic int tap_idx(input int row, input int col);
    return row * 3 + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bayer_line_sdp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bayer_line_sdp : simple dual-port line RAM, 1-cycle registered rd |
// | Revision       : 1.0                                              |
// +------------------------------------------------------------------+
module bayer_line_sdp #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_ren,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  import bayer_pkg::*;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_wen) r_mem[i_waddr] <= i_wdata;
    if (i_ren) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/bayer_win3x3.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bayer_win3x3 : raster raw stream -> 3x3 window per pixel          |
// | Option BAYER_WIN_REPLICATE_EN: mirror invalid taps instead of 0   |
// | Revision     : 1.0                                                |
// +------------------------------------------------------------------+
module bayer_win3x3 import bayer_pkg::*; #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_vs,
  input  logic                           i_de,
  input  logic [DATA_WIDTH-1:0]          i_data,
  output logic                           o_vs,
  output logic                           o_de,
  output logic [WIN_TAPS*DATA_WIDTH-1:0] o_win,
  output logic                           o_x_odd,
  output logic                           o_y_odd,
  output logic                           o_ovf
);

  localparam logic [ADDR_WIDTH-1:0] c_XMAX = '1;

  logic                  r_vs_d, r_de_d, r_y_lsb, r_ovf;
  logic [ADDR_WIDTH-1:0] r_x;
  logic [1:0]            r_line_cnt;
  logic                  w_vs_rise, w_de_fall, w_hit, w_ylsb;
  logic [ADDR_WIDTH-1:0] w_x;
  logic [1:0]            w_lc;

  // A frame-start edge overrides the stored position for the pixel in the same cycle.
  assign w_vs_rise = i_vs & ~r_vs_d;
  assign w_de_fall = r_de_d & ~i_de;
  assign w_x       = w_vs_rise ? '0 : r_x;
  assign w_lc      = w_vs_rise ? 2'd0 : r_line_cnt;
  assign w_ylsb    = w_vs_rise ? 1'b0 : r_y_lsb;
  assign w_hit     = i_de & (w_x == c_XMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d     <= 1'b0;
      r_de_d     <= 1'b0;
      r_x        <= '0;
      r_line_cnt <= 2'd0;
      r_y_lsb    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_vs_d <= i_vs;
      r_de_d <= i_de;
      r_x    <= i_de ? (w_hit ? c_XMAX : w_x + ADDR_WIDTH'(1)) : '0;
      if (w_vs_rise) begin
        r_line_cnt <= 2'd0;
        r_y_lsb    <= 1'b0;
        r_ovf      <= 1'b0;
      end else begin
        if (w_de_fall) begin
          if (r_line_cnt != 2'd2) r_line_cnt <= r_line_cnt + 2'd1;
          r_y_lsb <= ~r_y_lsb;
        end
        if (w_hit) r_ovf <= 1'b1;
      end
    end
  end

  logic                  r1_vs, r1_de, r1_wen, r1_ylsb;
  logic [DATA_WIDTH-1:0] r1_data;
  logic [ADDR_WIDTH-1:0] r1_x;
  logic [1:0]            r1_lc;
  logic [DATA_WIDTH-1:0] w_a_q, w_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_vs   <= 1'b0;
      r1_de   <= 1'b0;
      r1_wen  <= 1'b0;
      r1_ylsb <= 1'b0;
      r1_data <= '0;
      r1_x    <= '0;
      r1_lc   <= 2'd0;
    end else begin
      r1_vs   <= i_vs;
      r1_de   <= i_de;
      r1_wen  <= i_de & ~w_hit;
      r1_ylsb <= w_ylsb;
      r1_data <= i_data;
      r1_x    <= w_x;
      r1_lc   <= w_lc;
    end
  end

  // RAM A holds line y-1; B receives A's old contents, so it holds line y-2.
  bayer_line_sdp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram_a (
    .clk(clk), .i_wen(r1_wen), .i_waddr(r1_x), .i_wdata(r1_data),
    .i_ren(i_de), .i_raddr(w_x), .o_rdata(w_a_q)
  );

  bayer_line_sdp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram_b (
    .clk(clk), .i_wen(r1_wen), .i_waddr(r1_x), .i_wdata(w_a_q),
    .i_ren(i_de), .i_raddr(w_x), .o_rdata(w_b_q)
  );

  logic                  r2_vs, r2_de, r2_xodd, r2_yodd;
  logic [ADDR_WIDTH-1:0] r2_x;
  logic [1:0]            r2_lc;
  logic [DATA_WIDTH-1:0] r_col [3][3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_vs   <= 1'b0;
      r2_de   <= 1'b0;
      r2_xodd <= 1'b0;
      r2_yodd <= 1'b0;
      r2_x    <= '0;
      r2_lc   <= 2'd0;
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          r_col[c][r] <= '0;
    end else begin
      r2_vs <= r1_vs;
      r2_de <= r1_de;
      if (r1_de) begin
        r_col[0]    <= r_col[1];
        r_col[1]    <= r_col[2];
        r_col[2][0] <= w_b_q;
        r_col[2][1] <= w_a_q;
        r_col[2][2] <= r1_data;
        r2_x        <= r1_x;
        r2_lc       <= r1_lc;
        r2_xodd     <= ~r1_x[0];
        r2_yodd     <= ~r1_ylsb;
      end
    end
  end

  row_vld_t              w_rv;
  logic [2:0]            w_rvv, w_cv;
  logic [DATA_WIDTH-1:0] w_tap [3][3];
`ifdef BAYER_WIN_REPLICATE_EN
  logic [DATA_WIDTH-1:0] w_rm [3][3];
`endif

  assign w_rv.r0 = (r2_lc == 2'd2);
  assign w_rv.r1 = (r2_lc != 2'd0);
  assign w_rv.r2 = 1'b1;
  assign w_rvv   = {w_rv.r2, w_rv.r1, w_rv.r0};
  assign w_cv    = {1'b1, (r2_x != '0), (r2_x >= ADDR_WIDTH'(2))};

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w_tap[r][c] = '0;
`ifdef BAYER_WIN_REPLICATE_EN
    // Rows are mirrored first, then columns pick from the already-mirrored rows.
    for (int c = 0; c < 3; c++) begin
      w_rm[0][c] = w_rvv[0] ? r_col[c][0] : r_col[c][2];
      w_rm[1][c] = w_rvv[1] ? r_col[c][1] : r_col[c][2];
      w_rm[2][c] = r_col[c][2];
    end
    for (int r = 0; r < 3; r++) begin
      w_tap[r][0] = w_cv[0] ? w_rm[r][0] : w_rm[r][2];
      w_tap[r][1] = w_cv[1] ? w_rm[r][1] : w_rm[r][2];
      w_tap[r][2] = w_rm[r][2];
    end
`else
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (w_rvv[r] && w_cv[c]) w_tap[r][c] = r_col[c][r];
`endif
  end

  for (genvar gr = 0; gr < 3; gr++) begin : g_row
    for (genvar gc = 0; gc < 3; gc++) begin : g_col
      localparam int c_SLOT = R2C2 - tap_idx(gr, gc);
      assign o_win[c_SLOT*DATA_WIDTH +: DATA_WIDTH] = w_tap[gr][gc];
    end
  end

  assign o_vs    = r2_vs;
  assign o_de    = r2_de;
  assign o_x_odd = r2_xodd;
  assign o_y_odd = r2_yodd;
  assign o_ovf   = r_ovf;

endmodule
`default_nettype wire
